// File: rtl/my_cy_counter.sv
// Up/down counter with programmable step, registered carry/borrow pulse and terminal-count flag.
// Define MY_CY_COUNTER_SAT_EN to clamp on overflow instead of wrapping.
module my_cy_counter #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             C,
  input  logic             R,
  input  logic             CE,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] STEP,
  input  logic             UP,
  output logic [WIDTH-1:0] Q,
  output logic             CO,
  output logic             TC
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic [WIDTH:0]   res;
  logic [WIDTH-1:0] nxt;

  // top bit of the widened result is carry (add) or borrow (subtract)
  assign sum = {1'b0, Q} + {1'b0, STEP};
  assign dif = {1'b0, Q} - {1'b0, STEP};
  assign res = UP ? sum : dif;

`ifdef MY_CY_COUNTER_SAT_EN
  assign nxt = res[WIDTH] ? (UP ? '1 : '0) : res[WIDTH-1:0];
`else
  assign nxt = res[WIDTH-1:0];
`endif

  always_ff @(posedge C) begin
    priority case (1'b1)
      R: begin
        Q  <= INIT;
        CO <= 1'b0;
      end
      CE && LOAD: begin
        Q  <= D;
        CO <= 1'b0;
      end
      CE: begin
        Q  <= nxt;
        CO <= res[WIDTH];
      end
      default: begin
        CO <= 1'b0;
      end
    endcase
  end

  assign TC = UP ? (&Q) : (~|Q);

endmodule

// File: tb/tb_my_cy_counter.sv
// Randomized self-checking bench for my_cy_counter against an integer model.
// Honours MY_CY_COUNTER_SAT_EN for the expected overflow behaviour.
module tb_my_cy_counter;

  logic       C = 1'b0;
  always #5 C = ~C;

  logic       R, CE, LOAD, UP;
  logic [7:0] D, STEP, Q;
  logic       CO, TC;

  logic       R1, CE1, LOAD1, UP1;
  logic [0:0] D1, STEP1, Q1;
  logic       CO1, TC1;

  my_cy_counter #(.WIDTH(8), .INIT(8'h05)) dut (
    .C(C), .R(R), .CE(CE), .LOAD(LOAD), .D(D), .STEP(STEP),
    .UP(UP), .Q(Q), .CO(CO), .TC(TC)
  );

  my_cy_counter #(.WIDTH(1), .INIT(1'b0)) dut1 (
    .C(C), .R(R1), .CE(CE1), .LOAD(LOAD1), .D(D1), .STEP(STEP1),
    .UP(UP1), .Q(Q1), .CO(CO1), .TC(TC1)
  );

`ifdef MY_CY_COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  int pass_n  = 0;
  int total_n = 0;
  int mq      = 0;
  bit mco     = 1'b0;

  function automatic void model_edge();
    int t;
    if (R) begin
      mq = 5; mco = 1'b0;
    end else if (CE && LOAD) begin
      mq = int'(D); mco = 1'b0;
    end else if (CE) begin
      if (UP) t = mq + int'(STEP);
      else    t = mq - int'(STEP);
      mco = (t > 255) || (t < 0);
      if (mco) begin
        if (SAT) mq = UP ? 255 : 0;
        else     mq = UP ? t - 256 : t + 256;
      end else begin
        mq = t;
      end
    end else begin
      mco = 1'b0;
    end
  endfunction

  function automatic bit model_tc();
    return UP ? (mq == 255) : (mq == 0);
  endfunction

  task automatic tick();
    model_edge();
    @(posedge C);
    #1;
  endtask

  task automatic drive(bit r, bit ce, bit ld, bit up, int d, int st);
    R = r; CE = ce; LOAD = ld; UP = up; D = 8'(d); STEP = 8'(st);
  endtask

  task automatic test_reset();
    drive(1, 1, 0, 1, 0, 7);
    tick();
    drive(0, 0, 0, 1, 0, 7);
    for (int i = 0; i < 3; i++) begin
      tick();
      total_n++;
      if (Q !== 8'h05 || CO !== 1'b0 || TC !== 1'b0)
        $display("FAIL reset_hold[%0d] Q=%h CO=%b TC=%b want Q=05 CO=0 TC=0",
                 i, Q, CO, TC);
      else pass_n++;
    end
  endtask

  task automatic test_wrap_up();
    drive(0, 1, 1, 1, 8'hFE, 0);
    tick();
    drive(0, 1, 0, 1, 0, 3);
    tick();
    total_n++;
    if (Q !== (SAT ? 8'hFF : 8'h01) || CO !== 1'b1)
      $display("FAIL up_ovf Q=%h CO=%b want Q=%h CO=1",
               Q, CO, SAT ? 8'hFF : 8'h01);
    else pass_n++;
    drive(0, 0, 0, 1, 0, 3);
    tick();
    total_n++;
    if (CO !== 1'b0 || Q !== (SAT ? 8'hFF : 8'h01))
      $display("FAIL co_pulse Q=%h CO=%b want CO=0", Q, CO);
    else pass_n++;
  endtask

  task automatic test_wrap_down();
    drive(0, 1, 1, 0, 8'h02, 0);
    tick();
    drive(0, 1, 0, 0, 0, 5);
    tick();
    total_n++;
    if (Q !== (SAT ? 8'h00 : 8'hFD) || CO !== 1'b1 || TC !== SAT)
      $display("FAIL dn_ovf Q=%h CO=%b TC=%b want Q=%h CO=1 TC=%b",
               Q, CO, TC, SAT ? 8'h00 : 8'hFD, SAT);
    else pass_n++;
    drive(0, 1, 0, 0, 0, 0);
    tick();
    total_n++;
    if (Q !== (SAT ? 8'h00 : 8'hFD) || CO !== 1'b0)
      $display("FAIL step0 Q=%h CO=%b want CO=0 unchanged Q", Q, CO);
    else pass_n++;
  endtask

  task automatic test_reset_priority();
    drive(1, 1, 1, 1, 8'hAA, 1);
    tick();
    total_n++;
    if (Q !== 8'h05 || CO !== 1'b0)
      $display("FAIL rst_over_load Q=%h CO=%b want Q=05 CO=0", Q, CO);
    else pass_n++;
    drive(0, 1, 1, 1, 8'hAA, 1);
    tick();
    total_n++;
    if (Q !== 8'hAA || CO !== 1'b0)
      $display("FAIL load_after_rst Q=%h CO=%b want Q=aa CO=0", Q, CO);
    else pass_n++;
  endtask

  task automatic test_ce_gate_tc();
    drive(0, 1, 1, 1, 8'h10, 0);
    tick();
    drive(0, 0, 1, 1, 8'h33, 9);
    tick();
    total_n++;
    if (Q !== 8'h10)
      $display("FAIL ce_gates_load Q=%h want 10", Q);
    else pass_n++;
    drive(0, 1, 1, 1, 8'h00, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    total_n++;
    if (TC !== 1'b1) $display("FAIL tc_dn TC=%b want 1", TC);
    else pass_n++;
    UP = 1'b1;
    #1;
    total_n++;
    if (TC !== 1'b0) $display("FAIL tc_up TC=%b want 0", TC);
    else pass_n++;
  endtask

  task automatic test_random();
    int st;
    for (int i = 0; i < 400; i++) begin
      st = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255)
                                       : $urandom_range(0, 4);
      drive($urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 255), st);
      tick();
      total_n++;
      if (Q !== 8'(mq) || CO !== mco || TC !== model_tc())
        $display("FAIL rand[%0d] Q=%h CO=%b TC=%b want Q=%h CO=%b TC=%b",
                 i, Q, CO, TC, 8'(mq), mco, model_tc());
      else pass_n++;
    end
  endtask

  task automatic test_width1();
    int eq;
    bit eco;
    R1 = 1'b1; CE1 = 1'b1; LOAD1 = 1'b0; UP1 = 1'b1;
    D1 = 1'b0; STEP1 = 1'b1;
    @(posedge C); #1;
    R1 = 1'b0;
    eq = 0;
    for (int i = 0; i < 4; i++) begin
      eq = eq + 1;
      eco = eq > 1;
      if (eco) eq = SAT ? 1 : eq - 2;
      @(posedge C); #1;
      total_n++;
      if (Q1 !== 1'(eq) || CO1 !== eco)
        $display("FAIL w1[%0d] Q=%b CO=%b want Q=%b CO=%b",
                 i, Q1, CO1, 1'(eq), eco);
      else pass_n++;
    end
  endtask

  initial begin
    drive(1, 0, 0, 1, 0, 0);
    R1 = 1'b1; CE1 = 1'b0; LOAD1 = 1'b0; UP1 = 1'b1;
    D1 = 1'b0; STEP1 = 1'b0;
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_reset_priority();
    test_ce_gate_tc();
    test_random();
    test_width1();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
